// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite encodings and field widths used by the bus matrix input
// stage and its helpers.
//   htrans_e   : transfer type encodings (IDLE, BUSY, NONSEQ, SEQ)
//   hresp_e    : response encodings (OKAY, ERROR)
//   HTRANS_W, HSIZE_W, HBURST_W, HPROT_W : control field widths
//   is_req_trans() : true for transfer types that need a slave (NONSEQ/SEQ)
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam int HTRANS_W = 2;
  localparam int HSIZE_W  = 3;
  localparam int HBURST_W = 3;
  localparam int HPROT_W  = 4;

  function automatic logic is_req_trans(input logic [HTRANS_W-1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_addr_hold_reg.sv
// ahb_addr_hold_reg
// Enable-loaded register that captures a master's address/control phase so it
// can be replayed after the master has been stalled.
//   clk    in   clock
//   resetn in   synchronous active-low reset, clears the register to 0
//   en     in   load enable
//   d      in   WIDTH  packed address/control fields
//   q      out  WIDTH  held copy
module ahb_addr_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ahb_input_stage.sv
// ahb_input_stage
// Master-side end of the bus matrix. Forwards the live address phase of one
// AHB-Lite master to the output stage, or replays a registered copy when the
// output stage could not take it (lost arbitration or slave still busy), and
// stalls the master with HREADYOUTS=0 until the replayed phase is accepted.
// During the data phase the slave's ready/response are returned to the master.
//   HCLK, HRESETn               clock, synchronous active-low reset
//   HSELS..HMASTLOCKS, HREADYS  master-side address phase and HREADY
//   HREADYOUTS, HRESPS          ready/response back to the master
//   sel_ip..mastlock_ip         muxed address phase towards the output stage
//   held_tran_ip                a live or held transfer is requesting the slave
//   active_ip                   output stage has granted this port
//   ready_ip, resp_ip           slave HREADY/HRESP routed back by the output stage
module ahb_input_stage
  import ahb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MASTER_W = 4
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSELS,
  input  logic [ADDR_W-1:0]   HADDRS,
  input  logic [ADDR_W-1:0]   HAUSERS,
  input  logic [1:0]          HTRANSS,
  input  logic                HWRITES,
  input  logic [2:0]          HSIZES,
  input  logic [2:0]          HBURSTS,
  input  logic [3:0]          HPROTS,
  input  logic [MASTER_W-1:0] HMASTERS,
  input  logic                HMASTLOCKS,
  input  logic                HREADYS,
  output logic                HREADYOUTS,
  output logic                HRESPS,
  output logic                sel_ip,
  output logic [ADDR_W-1:0]   addr_ip,
  output logic [ADDR_W-1:0]   auser_ip,
  output logic [1:0]          trans_ip,
  output logic                write_ip,
  output logic [2:0]          size_ip,
  output logic [2:0]          burst_ip,
  output logic [3:0]          prot_ip,
  output logic [MASTER_W-1:0] master_ip,
  output logic                mastlock_ip,
  output logic                held_tran_ip,
  input  logic                active_ip,
  input  logic                ready_ip,
  input  logic                resp_ip
);

  // The transfer type is not stored: a replayed transfer is always issued as
  // NONSEQ because another master may have been interleaved in between.
  localparam int HOLD_W = 2 * ADDR_W + 1 + HSIZE_W + HBURST_W + HPROT_W + MASTER_W + 1;

  logic                trans_valid;
  logic                accept;
  logic                pend;
  logic                dphase;
  logic [HOLD_W-1:0]   live_bus;
  logic [HOLD_W-1:0]   held_bus;

  logic [ADDR_W-1:0]   held_addr;
  logic [ADDR_W-1:0]   held_auser;
  logic                held_write;
  logic [2:0]          held_size;
  logic [2:0]          held_burst;
  logic [3:0]          held_prot;
  logic [MASTER_W-1:0] held_master;
  logic                held_mastlock;

  assign trans_valid = HSELS & is_req_trans(HTRANSS) & HREADYS;
  assign accept      = active_ip & ready_ip;

  assign live_bus = {HADDRS, HAUSERS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS};

  // Captures every address phase the master completes; only consulted while
  // pend is set, at which point the master is stalled and cannot overwrite it.
  ahb_addr_hold_reg #(
    .WIDTH (HOLD_W)
  ) u_hold (
    .clk    (HCLK),
    .resetn (HRESETn),
    .en     (HSELS & HREADYS),
    .d      (live_bus),
    .q      (held_bus)
  );

  assign {held_addr, held_auser, held_write, held_size, held_burst,
          held_prot, held_master, held_mastlock} = held_bus;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      pend   <= 1'b0;
      dphase <= 1'b0;
    end else begin
      // A pending transfer is never dropped; it waits for a grant with the
      // slave ready, which also covers the second cycle of an ERROR response.
      if (pend) begin
        pend <= ~accept;
      end else begin
        pend <= trans_valid & ~accept;
      end
      dphase <= (accept & (pend | trans_valid)) | (dphase & ~ready_ip);
    end
  end

  always_comb begin
    if (pend) begin
      sel_ip      = 1'b1;
      addr_ip     = held_addr;
      auser_ip    = held_auser;
      trans_ip    = HTRANS_NONSEQ;
      write_ip    = held_write;
      size_ip     = held_size;
      burst_ip    = held_burst;
      prot_ip     = held_prot;
      master_ip   = held_master;
      mastlock_ip = held_mastlock;
    end else begin
      sel_ip      = HSELS & HREADYS;
      addr_ip     = HADDRS;
      auser_ip    = HAUSERS;
      trans_ip    = HTRANSS;
      write_ip    = HWRITES;
      size_ip     = HSIZES;
      burst_ip    = HBURSTS;
      prot_ip     = HPROTS;
      master_ip   = HMASTERS;
      mastlock_ip = HMASTLOCKS;
    end
  end

  assign held_tran_ip = pend | trans_valid;

  // The master is stalled while a held transfer waits; otherwise it sees the
  // slave's ready during a data phase and zero-wait OKAY when idle.
  assign HREADYOUTS = pend ? 1'b0 : (dphase ? ready_ip : 1'b1);
  assign HRESPS     = dphase ? resp_ip : HRESP_OKAY;

endmodule
